fpu_shared_arbiter: RTL and testbench
=====================================

// Module: fpu_shared_arbiter
// PURPOSE
//  Shares one pipelined FPU (add/sub/mul/i2f/f2i + exception logic) between C_NUM_REQ requesters.
//  Round-robin arbitration issues one op per cycle. An in-order tag FIFO routes each FPU result to its owner.
//  Per-requester sticky fflags {NV,DZ,OF,UF,NX} are accumulated from the FPU exception flags.
//  Sits between core-side FP request ports and the single FPU instance.
// PARAMETERS
//  C_NUM_REQ    2   number of requesters (>=2)
//  C_OP         32  operand/result width
//  C_CMD        fpu_defs::C_CMD  FPU opcode width
//  C_RM         fpu_defs::C_RM   rounding-mode width
//  C_TAG_DEPTH  4   max ops in flight (power of 2)
// PORTS
//  Clk_CI        in   1                  clock
//  Rst_RI        in   1                  reset, asynchronous, active-high
//  Req_SI        in   C_NUM_REQ          request valid, one bit per requester
//  Gnt_SO        out  C_NUM_REQ          grant, one-hot or 0, combinational
//  Operand_a_DI  in   C_NUM_REQ x C_OP   operand a per requester
//  Operand_b_DI  in   C_NUM_REQ x C_OP   operand b per requester
//  Op_SI         in   C_NUM_REQ x C_CMD  opcode per requester
//  RM_DI         in   C_NUM_REQ x C_RM   rounding mode per requester
//  FPU_Operand_a_DO / FPU_Operand_b_DO  out  C_OP   registered issue operands
//  FPU_Op_SO     out  C_CMD              registered opcode
//  FPU_RM_DO     out  C_RM               registered rounding mode
//  FPU_Enable_SO out  1                  registered issue strobe
//  FPU_Result_DI in   C_OP               FPU result
//  FPU_Valid_SI  in   1                  FPU result valid, in issue order
//  FPU_IV_SI / FPU_OF_SI / FPU_UF_SI / FPU_IX_SI  in  1  FPU exception flags, qualified by FPU_Valid_SI
//  Result_DO     out  C_OP               registered result, broadcast to all requesters
//  Valid_SO      out  C_NUM_REQ          registered one-hot result strobe
//  Fflags_DO     out  C_NUM_REQ x 5      sticky {NV,DZ,OF,UF,NX} per requester
//  Fflags_clr_SI in   C_NUM_REQ          clear sticky flags of requester i
//  Err_SO        out  1                  sticky protocol error
// BEHAVIOUR
//  Reset: all registered outputs 0, including FPU_Enable_SO, Valid_SO, Result_DO, Fflags_DO and Err_SO.
//    RR pointer = 0; tag FIFO empty.
//  Arbitration:
//    - Candidates = Req_SI when cnt < C_TAG_DEPTH; otherwise no grant.
//    - Pick the first set bit at or after the pointer, wrapping modulo C_NUM_REQ.
//    - On grant to k the pointer becomes (k+1) mod C_NUM_REQ. The pointer is unchanged with no grant.
//  Grant handshake:
//    - A request is consumed in the cycle Gnt_SO[k]=1.
//    - The requester holds its inputs until granted. No grant is issued when Req_SI[k]=0.
//  Issue: the cycle after a grant, FPU_Enable_SO=1 with the operands, opcode and RM latched from k.
//    With no grant, FPU_Enable_SO=0 and the data registers hold their values.
//  Tag FIFO:
//    - Push k in the grant cycle. Pop in any cycle with FPU_Valid_SI=1.
//    - cnt counts pushes minus pops. Push and pop in the same cycle leave cnt unchanged.
//    - Full uses the registered cnt only; a pop does not free a slot for a grant in the same cycle.
//  Return:
//    - One cycle after FPU_Valid_SI, Result_DO = FPU_Result_DI and Valid_SO = onehot(popped tag) for 1 cycle.
//    - Otherwise Valid_SO = 0 and Result_DO holds.
//  FPU_Valid_SI with the FIFO empty: no pop, no Valid_SO, Err_SO set until reset.
//  Fflags update, in the same cycle as Valid_SO:
//    - Fflags_DO[tag] |= {IV,1'b0,OF,UF,IX}. DZ stays 0 because the FPU has no divider.
//    - Fflags_clr_SI[i] zeroes requester i the next cycle.
//    - If a clear and a set for the same requester coincide, the new flags are the result (set wins over the old value).
//  Reset mid-operation discards in-flight tags. FPU results arriving after reset count as errors.
//    The FPU must therefore be reset by the same Rst_RI.
// STRUCTURE
//  fpu_defs additions: C_RM, C_FFLAG_NV/DZ/OF/UF/NX bit indices, fflags_t (5-bit typedef).
//  Sub-module fpu_tag_fifo: synchronous FIFO, width $clog2(C_NUM_REQ), depth C_TAG_DEPTH.
//    Outputs: count, full, empty, and head data without a read-latency cycle.
//  Top: RR arbiter + issue registers + return/flag registers.
// TESTING
//  1. Req=2'b11 held for 4 cycles, FPU latency 2, ADD 1.0+2.0 ->
//     grants alternate 01,10,01,10; FPU_Enable_SO 1 each cycle.
//     Valid_SO follows the order 01,10,01,10; Result_DO=32'h40400000 for the first op.
//  2. FPU stalls (no Valid) with Req=01 continuous ->
//     exactly 4 grants, then Gnt_SO=0. One FPU_Valid_SI -> the next grant comes the cycle after the pop, not the same cycle.
//  3. Requester 1 MUL inf*0 (7F800000 x 00000000) -> FPU_IV_SI=1.
//     Fflags_DO[1]=5'b10000, Fflags_DO[0]=0; Fflags_clr_SI=10 -> 0 next cycle.
//  4. Fflags_clr_SI[0] in the same cycle as a returning op for requester 0 with IX=1 ->
//     Fflags_DO[0]=5'b00001 afterwards.
//  5. FPU_Valid_SI pulse with no op in flight -> Err_SO=1, Valid_SO stays 0, Fflags unchanged.
//  6. Assert Rst_RI asynchronously mid-stream with 3 ops in flight ->
//     all outputs 0 immediately, cnt=0, the pointer restarts at requester 0.

Source files
------------

// File: rtl/fpu_shared_arbiter_pkg.sv
// fpu_shared_arbiter_pkg: FPU command/rounding widths, fflags layout and helpers shared by the arbiter slice.
package fpu_shared_arbiter_pkg;
    localparam int C_CMD_W = 4;
    localparam int C_RM_W = 3;
    localparam int C_FFLAG_NV = 4;
    localparam int C_FFLAG_DZ = 3;
    localparam int C_FFLAG_OF = 2;
    localparam int C_FFLAG_UF = 1;
    localparam int C_FFLAG_NX = 0;

    typedef logic [4:0] fflags_t;

    typedef enum logic [C_CMD_W-1:0] {
        FPU_ADD = 4'd0,
        FPU_SUB = 4'd1,
        FPU_MUL = 4'd2,
        FPU_I2F = 4'd3,
        FPU_F2I = 4'd4
    } fpu_cmd_e;

    // The FPU has no divider, so DZ is never raised.
    function automatic fflags_t pack_fflags(input logic iv, input logic of, input logic uf, input logic ix);
        fflags_t f;
        f = '0;
        f[C_FFLAG_NV] = iv;
        f[C_FFLAG_DZ] = 1'b0;
        f[C_FFLAG_OF] = of;
        f[C_FFLAG_UF] = uf;
        f[C_FFLAG_NX] = ix;
        return f;
    endfunction

    function automatic int rr_idx(input int ptr, input int offset, input int n);
        return (ptr + offset) % n;
    endfunction
endpackage

// File: rtl/fpu_shared_arbiter_tag_fifo.sv
// fpu_shared_arbiter_tag_fifo: in-order owner-tag FIFO with fall-through head, count, full and empty.
module fpu_shared_arbiter_tag_fifo #(
    parameter int W = 1,
    parameter int D = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [W-1:0]         push_data,
    input  logic                 pop,
    output logic [W-1:0]         head,
    output logic [$clog2(D):0]   count,
    output logic                 full,
    output logic                 empty
);
    localparam int AW = $clog2(D);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = count == CW'(D);
    assign empty = count == '0;

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fpu_shared_arbiter.sv
// fpu_shared_arbiter: round-robin sharing of one pipelined FPU, in-order result routing, sticky per-requester fflags.
module fpu_shared_arbiter
    import fpu_shared_arbiter_pkg::*;
#(
    parameter int C_NUM_REQ   = 2,
    parameter int C_OP        = 32,
    parameter int C_CMD       = C_CMD_W,
    parameter int C_RM        = C_RM_W,
    parameter int C_TAG_DEPTH = 4
) (
    input  logic                             Clk_CI,
    input  logic                             Rst_RI,
    input  logic [C_NUM_REQ-1:0]             Req_SI,
    output logic [C_NUM_REQ-1:0]             Gnt_SO,
    input  logic [C_NUM_REQ-1:0][C_OP-1:0]   Operand_a_DI,
    input  logic [C_NUM_REQ-1:0][C_OP-1:0]   Operand_b_DI,
    input  logic [C_NUM_REQ-1:0][C_CMD-1:0]  Op_SI,
    input  logic [C_NUM_REQ-1:0][C_RM-1:0]   RM_DI,
    output logic [C_OP-1:0]                  FPU_Operand_a_DO,
    output logic [C_OP-1:0]                  FPU_Operand_b_DO,
    output logic [C_CMD-1:0]                 FPU_Op_SO,
    output logic [C_RM-1:0]                  FPU_RM_DO,
    output logic                             FPU_Enable_SO,
    input  logic [C_OP-1:0]                  FPU_Result_DI,
    input  logic                             FPU_Valid_SI,
    input  logic                             FPU_IV_SI,
    input  logic                             FPU_OF_SI,
    input  logic                             FPU_UF_SI,
    input  logic                             FPU_IX_SI,
    output logic [C_OP-1:0]                  Result_DO,
    output logic [C_NUM_REQ-1:0]             Valid_SO,
    output fflags_t [C_NUM_REQ-1:0]          Fflags_DO,
    input  logic [C_NUM_REQ-1:0]             Fflags_clr_SI,
    output logic                             Err_SO
);
    localparam int TW = $clog2(C_NUM_REQ);
    localparam int CW = $clog2(C_TAG_DEPTH) + 1;

    logic [TW-1:0] ptr;
    logic [TW-1:0] gnt_idx;
    logic          gnt_any;
    logic [TW-1:0] tag_head;
    logic [CW-1:0] tag_cnt;
    logic          tag_full;
    logic          tag_empty;
    logic          pop;
    fflags_t       new_flags;

    assign pop       = FPU_Valid_SI && !tag_empty;
    assign new_flags = pack_fflags(FPU_IV_SI, FPU_OF_SI, FPU_UF_SI, FPU_IX_SI);

    // Scanning offsets downward lets the smallest offset from the pointer win.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = C_NUM_REQ - 1; i >= 0; i--) begin
            if (Req_SI[rr_idx(int'(ptr), i, C_NUM_REQ)] && tag_cnt < CW'(C_TAG_DEPTH)) begin
                gnt_any = 1'b1;
                gnt_idx = TW'(rr_idx(int'(ptr), i, C_NUM_REQ));
            end
        end
        Gnt_SO = C_NUM_REQ'(gnt_any) << gnt_idx;
    end

    fpu_shared_arbiter_tag_fifo #(
        .W (TW),
        .D (C_TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (Clk_CI),
        .rst       (Rst_RI),
        .push      (gnt_any && !tag_full),
        .push_data (gnt_idx),
        .pop       (pop),
        .head      (tag_head),
        .count     (tag_cnt),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            ptr              <= '0;
            FPU_Enable_SO    <= 1'b0;
            FPU_Operand_a_DO <= '0;
            FPU_Operand_b_DO <= '0;
            FPU_Op_SO        <= '0;
            FPU_RM_DO        <= '0;
            Result_DO        <= '0;
            Valid_SO         <= '0;
            Fflags_DO        <= '0;
            Err_SO           <= 1'b0;
        end else begin
            FPU_Enable_SO <= gnt_any;
            if (gnt_any) begin
                FPU_Operand_a_DO <= Operand_a_DI[gnt_idx];
                FPU_Operand_b_DO <= Operand_b_DI[gnt_idx];
                FPU_Op_SO        <= Op_SI[gnt_idx];
                FPU_RM_DO        <= RM_DI[gnt_idx];
                ptr              <= (int'(gnt_idx) == C_NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            end
            Valid_SO <= C_NUM_REQ'(pop) << tag_head;
            if (pop) Result_DO <= FPU_Result_DI;
            if (FPU_Valid_SI && tag_empty) Err_SO <= 1'b1;
            // Clear first, then OR in the returning flags, so a coinciding set survives the clear.
            for (int i = 0; i < C_NUM_REQ; i++) begin
                Fflags_DO[i] <= (Fflags_clr_SI[i] ? '0 : Fflags_DO[i]) |
                                ((pop && int'(tag_head) == i) ? new_flags : '0);
            end
        end
    end
endmodule

// File: tb/tb_fpu_shared_arbiter.sv
// tb_fpu_shared_arbiter: directed and random checks of the shared-FPU arbiter against a queue-based model.
module tb_fpu_shared_arbiter;
    import fpu_shared_arbiter_pkg::*;

    localparam int N = 2;
    localparam int OPW = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]              req, gnt, clr, valid;
    logic [N-1:0][OPW-1:0]     opa, opb;
    logic [N-1:0][C_CMD_W-1:0] op;
    logic [N-1:0][C_RM_W-1:0]  rm;
    logic [OPW-1:0]            fa, fb, fres, res;
    logic [C_CMD_W-1:0]        fop;
    logic [C_RM_W-1:0]         frm;
    logic                      fen, fvalid, fiv, fof, fuf, fix, err;
    fflags_t [N-1:0]           fflags;

    fpu_shared_arbiter #(
        .C_NUM_REQ   (N),
        .C_OP        (OPW),
        .C_CMD       (C_CMD_W),
        .C_RM        (C_RM_W),
        .C_TAG_DEPTH (DEPTH)
    ) dut (
        .Clk_CI           (clk),
        .Rst_RI           (rst),
        .Req_SI           (req),
        .Gnt_SO           (gnt),
        .Operand_a_DI     (opa),
        .Operand_b_DI     (opb),
        .Op_SI            (op),
        .RM_DI            (rm),
        .FPU_Operand_a_DO (fa),
        .FPU_Operand_b_DO (fb),
        .FPU_Op_SO        (fop),
        .FPU_RM_DO        (frm),
        .FPU_Enable_SO    (fen),
        .FPU_Result_DI    (fres),
        .FPU_Valid_SI     (fvalid),
        .FPU_IV_SI        (fiv),
        .FPU_OF_SI        (fof),
        .FPU_UF_SI        (fuf),
        .FPU_IX_SI        (fix),
        .Result_DO        (res),
        .Valid_SO         (valid),
        .Fflags_DO        (fflags),
        .Fflags_clr_SI    (clr),
        .Err_SO           (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of owners in flight plus the expected register contents.
    int             m_ptr;
    int             m_q[$];
    fflags_t        m_flags[N];
    logic           m_err, m_en;
    logic [OPW-1:0] m_a, m_b, m_res;
    logic [C_CMD_W-1:0] m_op;
    logic [C_RM_W-1:0]  m_rm;
    logic [N-1:0]   m_valid;
    int             last_g;
    logic [N-1:0]   obs_gnt;
    bit             auto_fpu;
    logic [1:0]     vpipe;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_q.delete();
        for (int i = 0; i < N; i++) m_flags[i] = '0;
        m_err = 0; m_en = 0; m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_rm = '0; m_valid = '0;
        last_g = -1;
        vpipe = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fvalid = 1'b0;
        model_reset();
        #1;
        chk("rst_en", fen, 0);
        chk("rst_valid", valid, 0);
        chk("rst_res", res, 0);
        chk("rst_fflags", fflags, 0);
        chk("rst_err", err, 0);
        chk("rst_opa", fa, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic step();
        int g;
        int t;
        if (auto_fpu) fvalid = vpipe[1];
        #2;
        g = -1;
        if (m_q.size() < DEPTH)
            for (int o = N - 1; o >= 0; o--) if (req[(m_ptr + o) % N]) g = (m_ptr + o) % N;
        obs_gnt = gnt;
        chk("gnt", gnt, (g < 0) ? 64'd0 : (64'd1 << g));
        @(posedge clk);
        m_valid = '0;
        for (int i = 0; i < N; i++) if (clr[i]) m_flags[i] = '0;
        if (fvalid && m_q.size() > 0) begin
            t = m_q.pop_front();
            m_valid = N'(1) << t;
            m_res = fres;
            m_flags[t] = m_flags[t] | {fiv, 1'b0, fof, fuf, fix};
        end else if (fvalid) begin
            m_err = 1'b1;
        end
        m_en = g >= 0;
        if (g >= 0) begin
            m_a = opa[g]; m_b = opb[g]; m_op = op[g]; m_rm = rm[g];
            m_q.push_back(g);
            m_ptr = (g + 1) % N;
        end
        last_g = g;
        vpipe = {vpipe[0], m_en};
        #1;
        chk("fpu_en", fen, m_en);
        chk("fpu_a", fa, m_a);
        chk("fpu_b", fb, m_b);
        chk("fpu_op", fop, m_op);
        chk("fpu_rm", frm, m_rm);
        chk("valid", valid, m_valid);
        chk("result", res, m_res);
        chk("err", err, m_err);
        for (int i = 0; i < N; i++) chk("fflags", fflags[i], m_flags[i]);
    endtask

    initial begin
        int ngr;
        logic [N-1:0] vq[$];
        logic [N-1:0] exp_g[4];
        bit first_seen;
        req = '0; clr = '0; opa = '0; opb = '0; op = '0; rm = '0;
        fres = '0; fvalid = 0; fiv = 0; fof = 0; fuf = 0; fix = 0;
        auto_fpu = 0;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();

        // 1: both requesting ADD 1.0+2.0, FPU answers two cycles after issue.
        for (int i = 0; i < N; i++) begin
            opa[i] = 32'h3F800000; opb[i] = 32'h40000000; op[i] = FPU_ADD; rm[i] = '0;
        end
        fres = 32'h40400000;
        auto_fpu = 1;
        req = 2'b11;
        first_seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) req = 2'b00;
            step();
            if (c < 4) chk("t1_gnt", obs_gnt, exp_g[c]);
            if (c < 4) chk("t1_en", fen, 1);
            if (valid != 0) begin
                vq.push_back(valid);
                if (!first_seen) chk("t1_res", res, 32'h40400000);
                first_seen = 1;
            end
        end
        auto_fpu = 0;
        fvalid = 0;
        chk("t1_nvalid", vq.size(), 4);
        for (int i = 0; i < 4 && i < vq.size(); i++) chk("t1_order", vq[i], exp_g[i]);

        // 2: FPU stalls; only DEPTH grants fit, a pop frees a slot one cycle later.
        do_reset();
        req = 2'b01;
        ngr = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (obs_gnt != 0) ngr++;
        end
        chk("t2_grants", ngr, 4);
        fvalid = 1; fres = 32'h12345678;
        step();
        chk("t2_nogrant_on_pop", obs_gnt, 0);
        fvalid = 0;
        step();
        chk("t2_grant_after_pop", obs_gnt, 2'b01);
        req = 2'b00;
        fvalid = 1;
        for (int c = 0; c < 4; c++) step();
        fvalid = 0;

        // 3: requester 1 MUL inf*0 raises NV only on its own flags.
        opa[1] = 32'h7F800000; opb[1] = 32'h00000000; op[1] = FPU_MUL;
        req = 2'b10;
        step();
        req = 2'b00;
        step();
        fvalid = 1; fiv = 1; fres = 32'h7FC00000;
        step();
        fvalid = 0; fiv = 0;
        chk("t3_flags1", fflags[1], 5'b10000);
        chk("t3_flags0", fflags[0], 5'b00000);
        clr = 2'b10;
        step();
        clr = 2'b00;
        chk("t3_cleared", fflags[1], 5'b00000);

        // 4: a clear coinciding with a returning IX op leaves only the new flags.
        req = 2'b01;
        step();
        req = 2'b00;
        step();
        fvalid = 1; fof = 1; fres = 32'h7F800000;
        step();
        fvalid = 0; fof = 0;
        chk("t4_pre", fflags[0], 5'b00100);
        req = 2'b01;
        step();
        req = 2'b00;
        step();
        fvalid = 1; fix = 1; clr = 2'b01; fres = 32'h3EAAAAAB;
        step();
        fvalid = 0; fix = 0; clr = 2'b00;
        chk("t4_set_wins", fflags[0], 5'b00001);

        // 5: spurious FPU valid with nothing in flight.
        fvalid = 1; fof = 1;
        step();
        fvalid = 0; fof = 0;
        chk("t5_err", err, 1);
        chk("t5_valid", valid, 0);
        chk("t5_flags0", fflags[0], 5'b00001);

        // 6: asynchronous reset with three ops in flight.
        req = 2'b11;
        for (int c = 0; c < 3; c++) step();
        chk("t6_inflight", m_q.size(), 3);
        do_reset();
        step();
        chk("t6_ptr_restart", obs_gnt, 2'b01);
        req = 2'b01;
        ngr = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (obs_gnt != 0) ngr++;
        end
        chk("t6_cnt_cleared", ngr, 3);
        req = 2'b00;
        fvalid = 1;
        for (int c = 0; c < 4; c++) step();
        fvalid = 0;

        // Random traffic; requesters hold their request until granted.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || last_g == i) begin
                    req[i] = 1'($urandom_range(0, 1));
                    opa[i] = $urandom; opb[i] = $urandom;
                    op[i] = C_CMD_W'($urandom_range(0, 4));
                    rm[i] = C_RM_W'($urandom);
                end
            end
            fvalid = (m_q.size() > 0) && ($urandom_range(0, 9) < 4);
            fres = $urandom;
            {fiv, fof, fuf, fix} = 4'($urandom);
            clr = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
